// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order commit buffer with CDB capture and mispredict flush
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 issue_valid,
    input  logic                 issue_has_rd,
    input  logic [4:0]           issue_rd_index,
    input  logic                 issue_is_branch,
    input  logic                 issue_pred_taken,
    output logic [ROB_IDX_W-1:0] issue_rename,
    output logic                 rob_full,
    input  logic                 cdb_valid,
    input  logic [ROB_IDX_W-1:0] cdb_rename,
    input  logic [31:0]          cdb_value,
    input  logic                 cdb_taken,
    input  logic [31:0]          cdb_target,
    input  logic [ROB_IDX_W-1:0] query1_rename,
    input  logic [ROB_IDX_W-1:0] query2_rename,
    output logic                 query1_ready,
    output logic                 query2_ready,
    output logic [31:0]          query1_value,
    output logic [31:0]          query2_value,
    output logic                 rob_enable,
    output logic [4:0]           rob_commit_index,
    output logic [ROB_IDX_W-1:0] rob_commit_rename,
    output logic [31:0]          rob_commit_value,
    output logic                 jump_wrong,
    output logic [31:0]          jump_pc
);

    logic [ROB_DEPTH-1:0] busy_q, ready_q, has_rd_q, is_branch_q, pred_q, taken_q;
    logic [4:0]           rd_q     [ROB_DEPTH];
    logic [31:0]          value_q  [ROB_DEPTH];
    logic [31:0]          target_q [ROB_DEPTH];
    logic [ROB_IDX_W-1:0] head_q, tail_q;
    logic [ROB_IDX_W:0]   count_q;

    logic                 rob_enable_q, jump_wrong_q;
    logic [4:0]           commit_index_q;
    logic [ROB_IDX_W-1:0] commit_rename_q;
    logic [31:0]          commit_value_q, jump_pc_q;

    logic issue_fire, wb_fire, commit_fire, mispredict;

    assign rob_full     = (count_q == (ROB_IDX_W+1)'(ROB_DEPTH));
    assign issue_rename = tail_q;

    assign issue_fire  = rdy && issue_valid && !rob_full && !jump_wrong_q;
    assign wb_fire     = rdy && cdb_valid && !jump_wrong_q && busy_q[cdb_rename];
    assign commit_fire = rdy && !jump_wrong_q && (count_q != '0)
                         && busy_q[head_q] && ready_q[head_q];
    assign mispredict  = commit_fire && is_branch_q[head_q]
                         && (taken_q[head_q] != pred_q[head_q]);

    // Stored result wins; otherwise forward a same-cycle CDB broadcast.
    assign query1_ready = ready_q[query1_rename] || (cdb_valid && cdb_rename == query1_rename);
    assign query2_ready = ready_q[query2_rename] || (cdb_valid && cdb_rename == query2_rename);
    assign query1_value = ready_q[query1_rename] ? value_q[query1_rename] :
                          (cdb_valid && cdb_rename == query1_rename) ? cdb_value : 32'd0;
    assign query2_value = ready_q[query2_rename] ? value_q[query2_rename] :
                          (cdb_valid && cdb_rename == query2_rename) ? cdb_value : 32'd0;

    assign rob_enable        = rob_enable_q;
    assign rob_commit_index  = commit_index_q;
    assign rob_commit_rename = commit_rename_q;
    assign rob_commit_value  = commit_value_q;
    assign jump_wrong        = jump_wrong_q;
    assign jump_pc           = jump_pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q          <= '0;
            ready_q         <= '0;
            has_rd_q        <= '0;
            is_branch_q     <= '0;
            pred_q          <= '0;
            taken_q         <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rd_q[i]     <= '0;
                value_q[i]  <= '0;
                target_q[i] <= '0;
            end
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            rob_enable_q    <= 1'b0;
            jump_wrong_q    <= 1'b0;
            commit_index_q  <= '0;
            commit_rename_q <= '0;
            commit_value_q  <= '0;
            jump_pc_q       <= '0;
        end else if (jump_wrong_q) begin
            // Flush proceeds even when frozen so wrong-path entries never survive.
            busy_q       <= '0;
            ready_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rob_enable_q <= 1'b0;
            jump_wrong_q <= 1'b0;
        end else if (!rdy) begin
            rob_enable_q <= 1'b0;
            jump_wrong_q <= 1'b0;
        end else begin
            if (wb_fire) begin
                ready_q[cdb_rename]  <= 1'b1;
                value_q[cdb_rename]  <= cdb_value;
                taken_q[cdb_rename]  <= cdb_taken;
                target_q[cdb_rename] <= cdb_target;
            end
            if (issue_fire) begin
                busy_q[tail_q]      <= 1'b1;
                ready_q[tail_q]     <= 1'b0;
                has_rd_q[tail_q]    <= issue_has_rd;
                rd_q[tail_q]        <= issue_rd_index;
                is_branch_q[tail_q] <= issue_is_branch;
                pred_q[tail_q]      <= issue_pred_taken;
                tail_q              <= tail_q + 1'b1;
            end
            rob_enable_q <= commit_fire && has_rd_q[head_q];
            jump_wrong_q <= mispredict;
            if (commit_fire) begin
                busy_q[head_q]  <= 1'b0;
                head_q          <= head_q + 1'b1;
                commit_index_q  <= rd_q[head_q];
                commit_rename_q <= head_q;
                commit_value_q  <= value_q[head_q];
            end
            if (mispredict)
                jump_pc_q <= target_q[head_q];
            if (issue_fire && !commit_fire)
                count_q <= count_q + 1'b1;
            else if (!issue_fire && commit_fire)
                count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid, issue_has_rd, issue_is_branch, issue_pred_taken;
    logic [4:0]  issue_rd_index;
    logic [3:0]  issue_rename;
    logic        rob_full;
    logic        cdb_valid, cdb_taken;
    logic [3:0]  cdb_rename;
    logic [31:0] cdb_value, cdb_target;
    logic [3:0]  query1_rename, query2_rename;
    logic        query1_ready, query2_ready;
    logic [31:0] query1_value, query2_value;
    logic        rob_enable;
    logic [4:0]  rob_commit_index;
    logic [3:0]  rob_commit_rename;
    logic [31:0] rob_commit_value;
    logic        jump_wrong;
    logic [31:0] jump_pc;

    int checks = 0;
    int failures = 0;

    reorder_buffer #(.ROB_DEPTH(16), .ROB_IDX_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd),
        .issue_rd_index(issue_rd_index), .issue_is_branch(issue_is_branch),
        .issue_pred_taken(issue_pred_taken), .issue_rename(issue_rename),
        .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_rename(cdb_rename), .cdb_value(cdb_value),
        .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .query1_rename(query1_rename), .query2_rename(query2_rename),
        .query1_ready(query1_ready), .query2_ready(query2_ready),
        .query1_value(query1_value), .query2_value(query2_value),
        .rob_enable(rob_enable), .rob_commit_index(rob_commit_index),
        .rob_commit_rename(rob_commit_rename), .rob_commit_value(rob_commit_value),
        .jump_wrong(jump_wrong), .jump_pc(jump_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic has_rd, input logic [4:0] rd,
                             input logic br, input logic pred);
        issue_valid      = v;
        issue_has_rd     = has_rd;
        issue_rd_index   = rd;
        issue_is_branch  = br;
        issue_pred_taken = pred;
    endtask

    task automatic set_cdb(input logic v, input logic [3:0] tag, input logic [31:0] val,
                           input logic taken, input logic [31:0] target);
        cdb_valid  = v;
        cdb_rename = tag;
        cdb_value  = val;
        cdb_taken  = taken;
        cdb_target = target;
    endtask

    function automatic logic [4:0] rd_of(input int t);
        if (t == 4) return 5'd20;
        if (t == 5) return 5'd21;
        if (t >= 6) return 5'(t - 3);
        return 5'(t + 13);
    endfunction

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        set_issue(0, 0, 0, 0, 0);
        set_cdb(0, 0, 0, 0, 0);
        query1_rename = 0;
        query2_rename = 0;

        // Reset state
        tick();
        tick();
        check("rst_enable", rob_enable, 0);
        check("rst_jump_wrong", jump_wrong, 0);
        check("rst_jump_pc", jump_pc, 0);
        check("rst_commit_value", rob_commit_value, 0);
        check("rst_issue_rename", issue_rename, 0);
        check("rst_full", rob_full, 0);
        rst = 1'b1;

        // In-order commit of out-of-order results
        set_issue(1, 1, 5, 0, 0);
        check("t1_tag0", issue_rename, 0);
        tick();
        set_issue(1, 1, 6, 0, 0);
        check("t1_tag1", issue_rename, 1);
        tick();
        set_issue(1, 1, 7, 0, 0);
        check("t1_tag2", issue_rename, 2);
        tick();
        set_issue(0, 0, 0, 0, 0);
        set_cdb(1, 1, 32'h11, 0, 0);
        tick();
        check("t1_no_commit_a", rob_enable, 0);
        set_cdb(1, 0, 32'hAA, 0, 0);
        tick();
        check("t1_no_commit_b", rob_enable, 0);
        set_cdb(1, 2, 32'h22, 0, 0);
        tick();
        check("t1_c0_en", rob_enable, 1);
        check("t1_c0_idx", rob_commit_index, 5);
        check("t1_c0_tag", rob_commit_rename, 0);
        check("t1_c0_val", rob_commit_value, 32'hAA);
        set_cdb(0, 0, 0, 0, 0);
        tick();
        check("t1_c1_en", rob_enable, 1);
        check("t1_c1_idx", rob_commit_index, 6);
        check("t1_c1_val", rob_commit_value, 32'h11);
        tick();
        check("t1_c2_en", rob_enable, 1);
        check("t1_c2_idx", rob_commit_index, 7);
        check("t1_c2_val", rob_commit_value, 32'h22);
        tick();
        check("t1_empty_en", rob_enable, 0);

        // Same-cycle CDB bypass, then stored value
        set_issue(1, 1, 8, 0, 0);
        tick();
        set_issue(0, 0, 0, 0, 0);
        set_cdb(1, 3, 32'hDEAD, 0, 0);
        query1_rename = 3;
        query2_rename = 4;
        #1;
        check("t4_bypass_rdy", query1_ready, 1);
        check("t4_bypass_val", query1_value, 32'hDEAD);
        check("t4_q2_rdy", query2_ready, 0);
        check("t4_q2_val", query2_value, 0);
        tick();
        set_cdb(0, 0, 0, 0, 0);
        #1;
        check("t4_stored_rdy", query1_ready, 1);
        check("t4_stored_val", query1_value, 32'hDEAD);
        tick();
        check("t4_commit_en", rob_enable, 1);
        check("t4_commit_idx", rob_commit_index, 8);
        check("t4_commit_val", rob_commit_value, 32'hDEAD);
        tick();

        // Fill to full with tail wrap, refused issue, commit/issue interplay
        check("t2_start_tag", issue_rename, 4);
        for (int i = 0; i < 16; i++) begin
            set_issue(1, 1, 5'(i + 1), 0, 0);
            tick();
        end
        check("t2_full", rob_full, 1);
        check("t2_tail_wrapped", issue_rename, 4);
        set_issue(1, 1, 5'd30, 0, 0);
        tick();
        check("t2_refused_tail", issue_rename, 4);
        check("t2_refused_full", rob_full, 1);
        set_cdb(1, 4, 32'h44, 0, 0);
        tick();
        check("t2_still_full", rob_full, 1);
        set_cdb(1, 5, 32'h55, 0, 0);
        tick();
        check("t2_commit4_en", rob_enable, 1);
        check("t2_commit4_idx", rob_commit_index, 1);
        check("t2_commit4_val", rob_commit_value, 32'h44);
        check("t2_issue_refused", issue_rename, 4);
        check("t2_not_full", rob_full, 0);
        set_cdb(0, 0, 0, 0, 0);
        set_issue(1, 1, 5'd20, 0, 0);
        tick();
        check("t2_commit5_val", rob_commit_value, 32'h55);
        check("t2_both_tail", issue_rename, 5);
        check("t2_both_full", rob_full, 0);
        set_issue(1, 1, 5'd21, 0, 0);
        tick();
        set_issue(0, 0, 0, 0, 0);
        check("t2_refull", rob_full, 1);
        check("t2_refull_en", rob_enable, 0);

        // Drain all 16 entries, head wraps 15 -> 0
        for (int k = 0; k < 16; k++) begin
            set_cdb(1, 4'((6 + k) % 16), 32'h100 + 32'((6 + k) % 16), 0, 0);
            tick();
            if (k >= 1) begin
                check("drain_tag", rob_commit_rename, 32'((6 + k - 1) % 16));
                check("drain_val", rob_commit_value, 32'h100 + 32'((6 + k - 1) % 16));
                check("drain_idx", rob_commit_index, rd_of((6 + k - 1) % 16));
            end
        end
        set_cdb(0, 0, 0, 0, 0);
        tick();
        check("drain_last_tag", rob_commit_rename, 5);
        check("drain_last_idx", rob_commit_index, 21);
        tick();
        check("drain_empty_en", rob_enable, 0);
        check("drain_empty_full", rob_full, 0);

        // Misprediction flush
        set_issue(1, 0, 0, 1, 0);
        check("t3_branch_tag", issue_rename, 6);
        tick();
        set_issue(1, 1, 9, 0, 0);
        tick();
        set_issue(0, 0, 0, 0, 0);
        set_cdb(1, 7, 32'h77, 0, 0);
        tick();
        set_cdb(1, 6, 32'h0, 1, 32'h1040);
        tick();
        set_cdb(0, 0, 0, 0, 0);
        tick();
        check("t3_jump_wrong", jump_wrong, 1);
        check("t3_jump_pc", jump_pc, 32'h1040);
        check("t3_branch_no_wr", rob_enable, 0);
        set_issue(1, 1, 10, 0, 0);
        tick();
        set_issue(0, 0, 0, 0, 0);
        check("t3_pulse_end", jump_wrong, 0);
        check("t3_flush_en", rob_enable, 0);
        check("t3_flush_tail", issue_rename, 0);
        tick();
        check("t3_younger_dropped", rob_enable, 0);
        check("t3_after_tail", issue_rename, 0);

        // rdy=0 freeze
        set_issue(1, 1, 11, 0, 0);
        tick();
        set_issue(0, 0, 0, 0, 0);
        set_cdb(1, 0, 32'hBEEF, 0, 0);
        tick();
        rdy = 1'b0;
        set_issue(1, 1, 12, 0, 0);
        set_cdb(1, 1, 32'h1234, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_frozen_en", rob_enable, 0);
        end
        check("t5_frozen_tail", issue_rename, 1);
        rdy = 1'b1;
        set_issue(0, 0, 0, 0, 0);
        set_cdb(0, 0, 0, 0, 0);
        tick();
        check("t5_resume_en", rob_enable, 1);
        check("t5_resume_idx", rob_commit_index, 11);
        check("t5_resume_val", rob_commit_value, 32'hBEEF);
        check("t5_resume_tail", issue_rename, 1);

        // Asynchronous reset mid-cycle with live entries
        for (int i = 0; i < 4; i++) begin
            set_issue(1, 1, 5'(i + 1), 0, 0);
            tick();
        end
        set_issue(0, 0, 0, 0, 0);
        check("t6_pre_tail", issue_rename, 5);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_val", rob_commit_value, 0);
        check("t6_async_idx", rob_commit_index, 0);
        check("t6_async_jpc", jump_pc, 0);
        check("t6_async_tail", issue_rename, 0);
        check("t6_async_full", rob_full, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_issue(1, 1, 3, 0, 0);
        check("t6_first_tag", issue_rename, 0);
        tick();
        set_issue(0, 0, 0, 0, 0);
        check("t6_second_tag", issue_rename, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order commit buffer for the Tomasulo core.
- Allocates one entry per issued instruction. That entry's index is the rename tag the register file records.
- Captures results from the CDB and retires entries in program order, driving the register file's commit port.
- Detects branch mispredictions at commit and broadcasts the flush (jump_wrong) to the rest of the core.

Parameters:
- ROB_DEPTH, 16, number of entries; must be a power of two.
- ROB_IDX_W, 4, log2(ROB_DEPTH); width of a rename tag.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-low reset
- rdy  input  1  global ready; low freezes the block
- issue_valid  input  1  decoder requests allocation this cycle
- issue_has_rd  input  1  instruction writes a register
- issue_rd_index  input  5  destination register
- issue_is_branch  input  1  instruction is a conditional branch or jalr
- issue_pred_taken  input  1  predicted direction
- issue_rename  output  ROB_IDX_W  tag that will be allocated (equals tail, combinational)
- rob_full  output  1  count==ROB_DEPTH (combinational)
- cdb_valid  input  1  result broadcast
- cdb_rename  input  ROB_IDX_W  tag of the result
- cdb_value  input  32  result value
- cdb_taken  input  1  actual branch direction
- cdb_target  input  32  correct next PC if the prediction was wrong
- query1_rename, query2_rename  input  ROB_IDX_W  operand tags from the decoder
- query1_ready, query2_ready  output  1  value available (combinational)
- query1_value, query2_value  output  32  forwarded value (combinational)
- rob_enable  output  1  commit strobe to the register file
- rob_commit_index  output  5  committed rd
- rob_commit_rename  output  ROB_IDX_W  committed tag
- rob_commit_value  output  32  committed value
- jump_wrong  output  1  misprediction flush pulse
- jump_pc  output  32  redirect PC

Behaviour:
- **Per-entry state:** busy, ready, has_rd, rd, value, is_branch, pred, taken, target. Pointers head and tail are ROB_IDX_W bits wide and wrap modulo ROB_DEPTH. count is ROB_IDX_W+1 bits wide.
- **Reset (rst=0, asynchronous):**
  - head, tail and count are 0.
  - All busy and ready flags are 0.
  - rob_enable=0, jump_wrong=0, and rob_commit_index, rob_commit_rename, rob_commit_value and jump_pc are 0.
- **rdy=0:** no state change; registered strobes rob_enable and jump_wrong go to 0 on the next edge.
- **Issue:** accepted on an edge when rdy, issue_valid, !rob_full and !jump_wrong. The entry at tail gets busy=1, ready=0 and the fields are latched; tail increments.
- **Issue while full:** if count==ROB_DEPTH, issue is refused even if a commit happens in the same cycle.
- **Writeback:**
  - On cdb_valid, the entry cdb_rename gets ready=1 and latches value, taken and target.
  - A writeback to a non-busy entry is ignored.
- **Commit:**
  - When rdy, count>0 and entry[head].busy && ready (registered state), the entry retires: busy is cleared and head increments.
  - Latency: a CDB write in cycle N is committable at edge N+1 at the earliest; rob_enable is asserted at edge N+1.
  - On retirement, the commit outputs are registered for one cycle: rob_enable=has_rd, rob_commit_index=rd, rob_commit_rename=head, rob_commit_value=value.
  - At most one retirement per cycle.
- **Misprediction:**
  - Triggered when the committing entry has is_branch and taken!=pred.
  - That edge registers jump_wrong=1 and jump_pc=target. rob_enable follows has_rd, so a jalr still writes its link value.
  - On the following edge (jump_wrong=1) the block flushes: head=tail=count=0 and all busy=0. Issue, writeback and commit are ignored in that cycle, and jump_wrong returns to 0.
- **count update:** +1 on issue, -1 on commit; unchanged when both happen in the same cycle.
- **Query:** queryX_ready=1 when entry[tag].ready. Otherwise, if cdb_valid && cdb_rename==tag, ready=1 and the value is taken from cdb_value (same-cycle bypass). Otherwise ready=0 and value=0.
- **Empty:** no commit; all strobes 0.
- **Wrap-around:** correct at tail 15→0 and head 15→0.

Test Plan:
1. Reset, then issue 3 instructions with rd=x5, x6, x7 → tags 0, 1, 2. CDB writes tag 1 (0x11), then tag 0 (0xAA), then tag 2 → commits occur in order 0, 1, 2 on consecutive cycles with rob_enable=1, index 5/6/7, value 0xAA/0x11/... ; nothing commits before tag 0 is ready.
2. Issue 16 instructions → rob_full=1 and a 17th issue_valid is refused. Commit one and issue one in the same cycle → count stays 16 until the refused cycle passes, and tail wraps to 0.
3. Branch with pred_taken=0, CDB taken=1, target 0x1040 → at commit jump_wrong=1, jump_pc=0x1040 for exactly one cycle. Next cycle count=0; a younger entry that was already ready is never committed.
4. query1_rename=3 while cdb_valid with rename 3 and value 0xDEAD → query1_ready=1 and query1_value=0xDEAD combinationally. The following cycle the value is still returned from stored entry state.
5. Hold rdy=0 for 5 cycles with a ready head → no commit, and issue/CDB inputs have no effect. With rdy=1 the commit occurs on the next edge.
6. Assert rst low between clock edges with 4 entries live → outputs clear immediately and count=0. After release, the first issue gets tag 0.
